// File: rtl/apb_delay_pkg.sv
// Shared types and helpers for the fractional APB delay injector.
// State encoding and the saturating adder used by the delay accumulator.
package apb_delay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DELAY = 2'd2,
        DONE  = 2'd3
    } apb_delay_state_e;

    // Widest accumulator the helper supports; instances zero-extend into it.
    localparam int ACC_MAX_W = 64;

    // Returns min(a + b, 2^w - 1); w must not exceed ACC_MAX_W.
    function automatic logic [ACC_MAX_W-1:0] sat_add(
        input logic [ACC_MAX_W-1:0] a,
        input logic [ACC_MAX_W-1:0] b,
        input int unsigned          w
    );
        logic [ACC_MAX_W:0] lim;
        logic [ACC_MAX_W:0] sum;
        lim = (ACC_MAX_W+1)'(1) << w;
        lim = lim - (ACC_MAX_W+1)'(1);
        sum = {1'b0, a} + {1'b0, b};
        return (sum > lim) ? lim[ACC_MAX_W-1:0] : sum[ACC_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/apb_delay_acc.sv
// Fractional delay accumulator: adds RATIO_NUM per stalled slave cycle
// (saturating), subtracts RATIO_DEN per stretch cycle, reports acc >= RATIO_DEN.
module apb_delay_acc
    import apb_delay_pkg::*;
#(
    parameter int          ACC_W     = 64,
    parameter int unsigned RATIO_NUM = 507701,
    parameter int unsigned RATIO_DEN = 100000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic ge_den
);

    localparam logic [ACC_W-1:0] NUM = ACC_W'(RATIO_NUM);
    localparam logic [ACC_W-1:0] DEN = ACC_W'(RATIO_DEN);

    logic [ACC_W-1:0]     acc;
    logic [ACC_MAX_W-1:0] acc_sum;

    assign acc_sum = sat_add(ACC_MAX_W'(acc), ACC_MAX_W'(NUM), ACC_W);
    assign ge_den  = (acc >= DEN);

    // The remainder left after a stretch carries into the next transaction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (inc) begin
            acc <= acc_sum[ACC_W-1:0];
        end else if (dec) begin
            acc <= acc - DEN;
        end
    end

endmodule

// File: rtl/apb_delayer_frac.sv
// APB delay injector: forwards a request to a slow slave, then stretches the
// observed wait time by RATIO_NUM/RATIO_DEN before returning a registered response.
module apb_delayer_frac
    import apb_delay_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int unsigned RATIO_NUM = 507701,
    parameter int unsigned RATIO_DEN = 100000,
    parameter int          ACC_W     = 64,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  delay_en,
    input  logic [ADDR_W-1:0]     in_paddr,
    input  logic                  in_psel,
    input  logic                  in_penable,
    input  logic [2:0]            in_pprot,
    input  logic                  in_pwrite,
    input  logic [DATA_W-1:0]     in_pwdata,
    input  logic [DATA_W/8-1:0]   in_pstrb,
    output logic                  in_pready,
    output logic [DATA_W-1:0]     in_prdata,
    output logic                  in_pslverr,
    output logic [ADDR_W-1:0]     out_paddr,
    output logic                  out_psel,
    output logic                  out_penable,
    output logic [2:0]            out_pprot,
    output logic                  out_pwrite,
    output logic [DATA_W-1:0]     out_pwdata,
    output logic [DATA_W/8-1:0]   out_pstrb,
    input  logic                  out_pready,
    input  logic [DATA_W-1:0]     out_prdata,
    input  logic                  out_pslverr,
    output apb_delay_state_e      state
);

    // Handshake: the upstream sees in_pready for exactly one cycle (DONE);
    // the downstream sees out_psel only in IDLE (pass-through) and WAIT.
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic             en_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             acc_inc;
    logic             acc_dec;
    logic             acc_clr;
    logic             ge_den;

    assign out_paddr  = in_paddr;
    assign out_pprot  = in_pprot;
    assign out_pwrite = in_pwrite;
    assign out_pwdata = in_pwdata;
    assign out_pstrb  = in_pstrb;

    // Gated by reset_n so an abort drops the downstream select immediately.
    assign out_psel    = reset_n && (((state == IDLE) && in_psel) || (state == WAIT));
    assign out_penable = in_penable && (state == WAIT);

    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
    assign acc_inc = (state == WAIT) && !out_pready && !tmo_hit && en_q;
    assign acc_clr = (state == WAIT) && !out_pready && tmo_hit && en_q;
    assign acc_dec = (state == DELAY) && ge_den;

    apb_delay_acc #(
        .ACC_W     (ACC_W),
        .RATIO_NUM (RATIO_NUM),
        .RATIO_DEN (RATIO_DEN)
    ) u_acc (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (acc_inc),
        .dec     (acc_dec),
        .clr     (acc_clr),
        .ge_den  (ge_den)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            en_q       <= 1'b0;
            tmo_cnt    <= '0;
            in_pready  <= 1'b0;
            in_prdata  <= '0;
            in_pslverr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_psel) begin
                        en_q    <= delay_en;
                        tmo_cnt <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (out_pready) begin
                        in_prdata  <= out_prdata;
                        in_pslverr <= out_pslverr;
                        if (en_q) begin
                            state <= DELAY;
                        end else begin
                            state     <= DONE;
                            in_pready <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        in_prdata  <= '0;
                        in_pslverr <= 1'b1;
                        state      <= DONE;
                        in_pready  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DELAY: begin
                    if (!ge_den) begin
                        state     <= DONE;
                        in_pready <= 1'b1;
                    end
                end
                DONE: begin
                    // Always return to IDLE so a held PSEL cannot re-trigger here.
                    state      <= IDLE;
                    in_pready  <= 1'b0;
                    in_prdata  <= '0;
                    in_pslverr <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_delayer_frac.sv
// Directed bench for apb_delayer_frac: three instances cover ratio 5/2 with
// timeout 8, ratio 3/2, and an 8-bit saturating accumulator (200/100, no timeout).
module tb_apb_delayer_frac;
  import apb_delay_pkg::*;

  logic clock;
  logic reset_n;

  logic [2:0]        delay_en;
  logic [2:0][31:0]  in_paddr;
  logic [2:0]        in_psel;
  logic [2:0]        in_penable;
  logic [2:0][2:0]   in_pprot;
  logic [2:0]        in_pwrite;
  logic [2:0][31:0]  in_pwdata;
  logic [2:0][3:0]   in_pstrb;
  logic [2:0]        in_pready;
  logic [2:0][31:0]  in_prdata;
  logic [2:0]        in_pslverr;
  logic [2:0][31:0]  out_paddr;
  logic [2:0]        out_psel;
  logic [2:0]        out_penable;
  logic [2:0][2:0]   out_pprot;
  logic [2:0]        out_pwrite;
  logic [2:0][31:0]  out_pwdata;
  logic [2:0][3:0]   out_pstrb;
  logic [2:0]        out_pready;
  logic [2:0][31:0]  out_prdata;
  logic [2:0]        out_pslverr;
  logic [2:0][1:0]   st;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  apb_delayer_frac #(.RATIO_NUM(5), .RATIO_DEN(2), .ACC_W(64), .TIMEOUT(8)) u_a (
    .clock(clock), .reset_n(reset_n), .delay_en(delay_en[0]),
    .in_paddr(in_paddr[0]), .in_psel(in_psel[0]), .in_penable(in_penable[0]),
    .in_pprot(in_pprot[0]), .in_pwrite(in_pwrite[0]), .in_pwdata(in_pwdata[0]),
    .in_pstrb(in_pstrb[0]), .in_pready(in_pready[0]), .in_prdata(in_prdata[0]),
    .in_pslverr(in_pslverr[0]), .out_paddr(out_paddr[0]), .out_psel(out_psel[0]),
    .out_penable(out_penable[0]), .out_pprot(out_pprot[0]), .out_pwrite(out_pwrite[0]),
    .out_pwdata(out_pwdata[0]), .out_pstrb(out_pstrb[0]), .out_pready(out_pready[0]),
    .out_prdata(out_prdata[0]), .out_pslverr(out_pslverr[0]), .state(st[0])
  );

  apb_delayer_frac #(.RATIO_NUM(3), .RATIO_DEN(2), .ACC_W(64), .TIMEOUT(4096)) u_b (
    .clock(clock), .reset_n(reset_n), .delay_en(delay_en[1]),
    .in_paddr(in_paddr[1]), .in_psel(in_psel[1]), .in_penable(in_penable[1]),
    .in_pprot(in_pprot[1]), .in_pwrite(in_pwrite[1]), .in_pwdata(in_pwdata[1]),
    .in_pstrb(in_pstrb[1]), .in_pready(in_pready[1]), .in_prdata(in_prdata[1]),
    .in_pslverr(in_pslverr[1]), .out_paddr(out_paddr[1]), .out_psel(out_psel[1]),
    .out_penable(out_penable[1]), .out_pprot(out_pprot[1]), .out_pwrite(out_pwrite[1]),
    .out_pwdata(out_pwdata[1]), .out_pstrb(out_pstrb[1]), .out_pready(out_pready[1]),
    .out_prdata(out_prdata[1]), .out_pslverr(out_pslverr[1]), .state(st[1])
  );

  apb_delayer_frac #(.RATIO_NUM(200), .RATIO_DEN(100), .ACC_W(8), .TIMEOUT(0)) u_c (
    .clock(clock), .reset_n(reset_n), .delay_en(delay_en[2]),
    .in_paddr(in_paddr[2]), .in_psel(in_psel[2]), .in_penable(in_penable[2]),
    .in_pprot(in_pprot[2]), .in_pwrite(in_pwrite[2]), .in_pwdata(in_pwdata[2]),
    .in_pstrb(in_pstrb[2]), .in_pready(in_pready[2]), .in_prdata(in_prdata[2]),
    .in_pslverr(in_pslverr[2]), .out_paddr(out_paddr[2]), .out_psel(out_psel[2]),
    .out_penable(out_penable[2]), .out_pprot(out_pprot[2]), .out_pwrite(out_pwrite[2]),
    .out_pwdata(out_pwdata[2]), .out_pstrb(out_pstrb[2]), .out_pready(out_pready[2]),
    .out_prdata(out_prdata[2]), .out_pslverr(out_pslverr[2]), .state(st[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Cycle 0 is the current cycle; the slave answers in WAIT cycle k (k=0: never).
  // delay_en is inverted after cycle 0 to show it is only sampled at accept.
  task automatic run_txn(input int id, input int k, input logic en,
                         input logic [31:0] rdata, input logic err, input logic hold,
                         output int lat, output logic [31:0] rd, output logic se);
    int   cyc;
    logic got;
    delay_en[id]   = en;
    in_psel[id]    = 1'b1;
    in_penable[id] = 1'b0;
    in_paddr[id]   = 32'h1000 + id;
    cyc = 0;
    got = 1'b0;
    lat = -1;
    rd  = 'x;
    se  = 1'bx;
    while (!got && cyc < 100) begin
      step();
      cyc++;
      in_penable[id] = 1'b1;
      delay_en[id]   = ~en;
      if (in_pready[id]) begin
        got = 1'b1;
        lat = cyc;
        rd  = in_prdata[id];
        se  = in_pslverr[id];
        check_eq("out_psel_in_done", out_psel[id], 1'b0);
      end
      out_pready[id]  = (cyc == k);
      out_prdata[id]  = rdata;
      out_pslverr[id] = err;
    end
    out_pready[id] = 1'b0;
    if (!hold) begin
      in_psel[id]    = 1'b0;
      in_penable[id] = 1'b0;
    end
  endtask

  // Leave DONE and confirm the response registers were cleared.
  task automatic after_done(input int id);
    step();
    check_eq("pready_cleared", in_pready[id], 1'b0);
    check_eq("prdata_cleared", in_prdata[id], 32'h0);
    check_eq("pslverr_cleared", in_pslverr[id], 1'b0);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        se;

    reset_n     = 1'b0;
    delay_en    = '0;
    in_paddr    = '0;
    in_psel     = '0;
    in_penable  = '0;
    in_pprot    = '0;
    in_pwrite   = '0;
    in_pwdata   = '0;
    in_pstrb    = '0;
    out_pready  = '0;
    out_prdata  = '0;
    out_pslverr = '0;

    repeat (3) @(posedge clock);
    #1;
    check_eq("reset_state", st[0], 2'(IDLE));
    check_eq("reset_pready", in_pready[0], 1'b0);
    check_eq("reset_prdata", in_prdata[0], 32'h0);
    check_eq("reset_acc", u_a.u_acc.acc, 64'd0);
    check_eq("reset_out_psel", out_psel[0], 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    in_paddr[0]  = 32'hABCD_0010;
    in_pwdata[0] = 32'h5A5A_A5A5;
    in_pstrb[0]  = 4'b1010;
    in_pprot[0]  = 3'b101;
    #1;
    check_eq("paddr_copy", out_paddr[0], 32'hABCD_0010);
    check_eq("pwdata_copy", out_pwdata[0], 32'h5A5A_A5A5);
    check_eq("pstrb_copy", out_pstrb[0], 4'b1010);
    check_eq("pprot_copy", out_pprot[0], 3'b101);

    // Ratio 5/2, k=3: D = 10/2 = 5 -> ready at cycle 10.
    run_txn(0, 3, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0, lat, rd, se);
    check_eq("ratio_lat", lat, 10);
    check_eq("ratio_rdata", rd, 32'hCAFE_0001);
    check_eq("ratio_err", se, 1'b0);
    check_eq("ratio_acc", u_a.u_acc.acc, 64'd0);
    after_done(0);

    // k=2: acc 5 -> D=2, remainder 1.
    run_txn(0, 2, 1'b1, 32'h0000_1111, 1'b0, 1'b0, lat, rd, se);
    check_eq("carry1_lat", lat, 6);
    check_eq("carry1_acc", u_a.u_acc.acc, 64'd1);
    after_done(0);

    // Bypass, k=4: ready at cycle 5, remainder untouched.
    run_txn(0, 4, 1'b0, 32'h0000_B0B0, 1'b0, 1'b0, lat, rd, se);
    check_eq("bypass_lat", lat, 5);
    check_eq("bypass_rdata", rd, 32'h0000_B0B0);
    check_eq("bypass_acc", u_a.u_acc.acc, 64'd1);
    after_done(0);

    // Carried remainder: 1 + 5 = 6 -> D=3; slave error passes through.
    run_txn(0, 2, 1'b1, 32'h0000_2222, 1'b1, 1'b0, lat, rd, se);
    check_eq("carry2_lat", lat, 7);
    check_eq("carry2_err", se, 1'b1);
    check_eq("carry2_acc", u_a.u_acc.acc, 64'd0);
    after_done(0);

    run_txn(0, 2, 1'b1, 32'h0000_3333, 1'b0, 1'b0, lat, rd, se);
    check_eq("pre_tmo_acc", u_a.u_acc.acc, 64'd1);
    after_done(0);

    // Timeout 8: slave silent -> DONE at cycle 9 with error, acc cleared.
    run_txn(0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, lat, rd, se);
    check_eq("tmo_lat", lat, 9);
    check_eq("tmo_rdata", rd, 32'h0);
    check_eq("tmo_err", se, 1'b1);
    check_eq("tmo_acc", u_a.u_acc.acc, 64'd0);
    after_done(0);

    // Zero-wait slave with empty accumulator: no stretch.
    run_txn(0, 1, 1'b1, 32'h0000_4444, 1'b0, 1'b0, lat, rd, se);
    check_eq("zero_wait_lat", lat, 3);
    check_eq("zero_wait_rdata", rd, 32'h0000_4444);
    after_done(0);

    // Held PSEL through DONE: next request only starts from IDLE.
    run_txn(0, 1, 1'b1, 32'h0000_5555, 1'b0, 1'b1, lat, rd, se);
    check_eq("held_lat", lat, 3);
    step();
    check_eq("held_state_idle", st[0], 2'(IDLE));
    check_eq("held_out_psel_idle", out_psel[0], 1'b1);
    run_txn(0, 1, 1'b1, 32'h0000_5556, 1'b0, 1'b0, lat, rd, se);
    check_eq("held_next_lat", lat, 3);
    check_eq("held_next_rdata", rd, 32'h0000_5556);
    after_done(0);

    // Ratio 3/2: k=2 twice -> D=1 (rem 1), then D=2.
    run_txn(1, 2, 1'b1, 32'h0000_7001, 1'b0, 1'b0, lat, rd, se);
    check_eq("frac1_lat", lat, 5);
    check_eq("frac1_acc", u_b.u_acc.acc, 64'd1);
    after_done(1);
    run_txn(1, 2, 1'b1, 32'h0000_7002, 1'b0, 1'b0, lat, rd, se);
    check_eq("frac2_lat", lat, 6);
    check_eq("frac2_acc", u_b.u_acc.acc, 64'd0);
    after_done(1);

    // 8-bit accumulator: 200 + 200 saturates at 255 -> D=2, leaves 55.
    run_txn(2, 3, 1'b1, 32'h0000_8888, 1'b0, 1'b0, lat, rd, se);
    check_eq("sat_lat", lat, 7);
    check_eq("sat_acc", u_c.u_acc.acc, 8'd55);
    after_done(2);

    // Reset while stretching: everything drops, no pready.
    delay_en[0]   = 1'b1;
    in_psel[0]    = 1'b1;
    in_penable[0] = 1'b0;
    step();
    in_penable[0] = 1'b1;
    step();
    check_eq("wait_out_psel", out_psel[0], 1'b1);
    check_eq("wait_out_penable", out_penable[0], 1'b1);
    step();
    out_pready[0] = 1'b1;
    out_prdata[0] = 32'h0000_6666;
    step();
    out_pready[0] = 1'b0;
    check_eq("mid_state_delay", st[0], 2'(DELAY));
    check_eq("mid_acc", u_a.u_acc.acc, 64'd10);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_state", st[0], 2'(IDLE));
    check_eq("rst_out_psel", out_psel[0], 1'b0);
    check_eq("rst_out_penable", out_penable[0], 1'b0);
    check_eq("rst_pready", in_pready[0], 1'b0);
    check_eq("rst_prdata", in_prdata[0], 32'h0);
    check_eq("rst_acc", u_a.u_acc.acc, 64'd0);
    #1;
    reset_n       = 1'b1;
    in_psel[0]    = 1'b0;
    in_penable[0] = 1'b0;
    step();
    check_eq("post_rst_pready", in_pready[0], 1'b0);
    run_txn(0, 3, 1'b1, 32'h0000_9999, 1'b0, 1'b0, lat, rd, se);
    check_eq("post_rst_lat", lat, 10);
    check_eq("post_rst_rdata", rd, 32'h0000_9999);
    after_done(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_delayer_frac.md
# apb_delayer_frac

Parametrised APB delay injector placed between the APB crossbar and a slow peripheral model. Each slave wait cycle is stretched by a fractional ratio RATIO_NUM/RATIO_DEN, so simulated device latency matches a CPU clock that differs from the device clock. This generation adds the following relative to the fixed 32-bit delayer:
- width parameters;
- a runtime bypass;
- a slave timeout that returns an error;
- a saturating accumulator;
- a dedicated response state that cannot re-trigger on a held PSEL.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; STRB_W = DATA_W/8 (derived)
- RATIO_NUM, 507701, ratio numerator (scaled CPU/device ratio)
- RATIO_DEN, 100000, ratio denominator; must be nonzero
- ACC_W, 64, delay accumulator width
- TIMEOUT, 4096, max WAIT cycles before abort; 0 disables the timeout

Ports:
- clock  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- delay_en  in  1  0 = bypass the delay phase; sampled on IDLE→WAIT
- in_paddr/in_psel/in_penable/in_pprot/in_pwrite/in_pwdata/in_pstrb  in  ADDR_W/1/1/3/1/DATA_W/STRB_W  upstream APB request
- in_pready  out  1  registered upstream ready
- in_prdata  out  DATA_W  registered read data
- in_pslverr  out  1  registered error
- out_paddr/out_pprot/out_pwrite/out_pwdata/out_pstrb  out  same widths  combinational copies of the in_* fields
- out_psel  out  1  downstream select
- out_penable  out  1  in_penable AND state==WAIT
- out_pready  in  1  downstream ready
- out_prdata  in  DATA_W  downstream read data
- out_pslverr  in  1  downstream error

## Operation
States: IDLE, WAIT, DELAY, DONE.

- **IDLE**
  - out_psel = in_psel (combinational).
  - If in_psel: latch en_q = delay_en, clear tmo_cnt, go WAIT.
- **WAIT**
  - out_psel = 1.
  - If out_pready: capture out_prdata and out_pslverr into the response registers; go DELAY if en_q, else go DONE.
  - Else if TIMEOUT != 0 and tmo_cnt == TIMEOUT-1: prdata = 0, pslverr = 1; go DONE. If en_q, the accumulator is cleared to 0.
  - Else: acc += RATIO_NUM, saturating at 2^ACC_W-1 with no wrap; tmo_cnt++.
- **DELAY**
  - out_psel = 0.
  - If acc < RATIO_DEN: go DONE. The remainder stays in acc and carries into the next transaction.
  - Else: acc -= RATIO_DEN.
- **DONE**
  - in_pready = 1 for exactly this one cycle; out_psel = 0; in_psel is ignored.
  - Next state is IDLE.
  - in_prdata and in_pslverr hold their values during DONE and are cleared to 0 when the state leaves DONE.
- **Bypass (en_q = 0):** acc is neither incremented nor decremented.

## Timing
- Reset (reset_n low, asynchronous): state = IDLE; acc, tmo_cnt, en_q, in_pready, in_prdata, in_pslverr all 0.
- A reset asserted mid-transaction aborts it immediately. No pready is issued, and out_psel drops in the same cycle.
- Notation: request accepted at cycle 0; slave ready at cycle k≥1 (k = number of WAIT cycles); a0 = acc at cycle 0.
- Bypass: in_pready high at cycle k+1.
- Delayed: in_pready high at cycle k+2+D, where D = floor((a0 + (k−1)·RATIO_NUM)/RATIO_DEN).
- Zero-wait slave (ready at k=1): no accumulation; D = floor(a0/RATIO_DEN), i.e. 0 unless a carried remainder is ≥ RATIO_DEN.
- All arithmetic is unsigned ACC_W-bit; RATIO_NUM and RATIO_DEN are zero-extended.
- Back-to-back requests: at least one IDLE cycle separates two transactions.

## Structure
- Package apb_delay_pkg holds the state enum apb_delay_state_e (IDLE, WAIT, DELAY, DONE) and a sat_add function.
- One sub-module, apb_delay_acc, contains the accumulator, saturation logic and compare. Its ports: inc, dec, clr, ge_den.
- The top level contains the FSM, response registers and timeout counter.

## Test plan
- **Ratio accounting:** NUM=5, DEN=2, acc=0; slave ready at k=3 → D = floor(10/2) = 5; pready at cycle 10; prdata equals the slave's value.
- **Fractional carry:** NUM=3, DEN=2; two transactions, each with k=2 → first D=1 with remainder 1; second D = floor(4/2) = 2.
- **Bypass:** delay_en=0, k=4 → pready at cycle 5; acc unchanged. Toggling delay_en mid-WAIT has no effect.
- **Timeout:** TIMEOUT=8, slave never ready → out_psel drops after 8 WAIT cycles; pready with pslverr=1, prdata=0; acc = 0 afterwards.
- **Held PSEL / saturation:**
  - Master holds in_psel through DONE → no second out_psel in DONE; the new transaction starts only from IDLE.
  - ACC_W=8, NUM=200, k=3 → acc saturates at 255, no wrap.
- **Reset mid-DELAY:** reset_n pulses low → all outputs 0 asynchronously, no pready; the next transaction behaves normally.
